// File: rtl/light_decoder.sv
// Decodes a 24-bit {R,G,B} light word to a debounced 3-bit colour and checks the selector's colour sequence.
// Optional STRICT_DECODE_EN macro: only 00/FF channel levels are legal; illegal runs are counted as errors.
module light_decoder #(
  parameter int          STABLE_CYCLES = 2,
  parameter logic [7:0]  THRESH        = 8'h80,
  parameter int          ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [23:0]          light,
  input  logic                 clr_err,
  output logic [2:0]           colour,
  output logic                 white,
  output logic                 colour_valid,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_t               state_q, state_d;
  logic [2:0]           class_q, class_d;
  logic                 illegal_q, illegal_d;
  logic                 illegal_prev_q, illegal_prev_d;
  logic [2:0]           cand_q, cand_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           colour_q, colour_d;
  logic                 white_q, white_d;
  logic                 valid_q, valid_d;
  logic                 serr_q, serr_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 accept;
  logic                 err_inc;
  logic [2:0]           expected;

  always_comb begin
    class_d = {light[23:16] >= THRESH, light[15:8] >= THRESH, light[7:0] >= THRESH};
`ifdef STRICT_DECODE_EN
    illegal_d = (light[23:16] != 8'h00 && light[23:16] != 8'hFF) ||
                (light[15:8]  != 8'h00 && light[15:8]  != 8'hFF) ||
                (light[7:0]   != 8'h00 && light[7:0]   != 8'hFF);
`else
    illegal_d = 1'b0;
`endif
    illegal_prev_d = illegal_q;

    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (illegal_q) begin
      cnt_d = 4'd0;
    end else if (class_q != cand_q) begin
      cand_d = class_q;
      cnt_d  = 4'd1;
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + 4'd1;
    end

    // Accept is evaluated on the next-state count so STABLE_CYCLES=1 accepts on the load cycle.
    accept   = !illegal_q && (cnt_d == STABLE) && (cand_d != colour_q);
    colour_d = accept ? cand_d : colour_q;
    white_d  = (colour_d == 3'b111);
    valid_d  = accept;

    // In TRACK the last accepted colour is always 1..6, so it doubles as the sequence history.
    expected = (colour_q == 3'd6) ? 3'd1 : colour_q + 3'd1;
    state_d  = state_q;
    serr_d   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (cand_d != 3'd0 && cand_d != 3'd7) state_d = TRACK;
        end
        TRACK: begin
          if (cand_d == expected) begin
            state_d = TRACK;
          end else if (cand_d == 3'd7) begin
            state_d = RESYNC;
          end else begin
            serr_d = 1'b1;
            if (cand_d == 3'd0) state_d = IDLE;
          end
        end
        RESYNC: begin
          if (cand_d == 3'd0)      state_d = IDLE;
          else if (cand_d != 3'd7) state_d = TRACK;
        end
        default: state_d = IDLE;
      endcase
    end

    err_inc = serr_d || (illegal_q && !illegal_prev_q);
    if (clr_err)                       err_d = '0;
    else if (err_inc && err_q != '1)   err_d = err_q + 1'b1;
    else                               err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      class_q        <= 3'd0;
      illegal_q      <= 1'b0;
      illegal_prev_q <= 1'b0;
      cand_q         <= 3'd0;
      cnt_q          <= 4'd0;
      colour_q       <= 3'd0;
      white_q        <= 1'b0;
      valid_q        <= 1'b0;
      serr_q         <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      class_q        <= class_d;
      illegal_q      <= illegal_d;
      illegal_prev_q <= illegal_prev_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      colour_q       <= colour_d;
      white_q        <= white_d;
      valid_q        <= valid_d;
      serr_q         <= serr_d;
      err_q          <= err_d;
    end
  end

  assign colour       = colour_q;
  assign white        = white_q;
  assign colour_valid = valid_q;
  assign seq_err      = serr_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_light_decoder.sv
// Directed table-driven bench for light_decoder (default parameters, STABLE_CYCLES=2).
module tb_light_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] light;
  logic        clr_err;
  logic [2:0]  colour;
  logic        white;
  logic        colour_valid;
  logic        seq_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int vld_cnt;
  int serr_cnt;

  light_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .light        (light),
    .clr_err      (clr_err),
    .colour       (colour),
    .white        (white),
    .colour_valid (colour_valid),
    .seq_err      (seq_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [23:0] light;
    int          cyc;
    logic [2:0]  colour;
    int          vld;
    int          serr;
    int          err;
    logic        white;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge, where inputs also change.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    vld_cnt  += int'(colour_valid);
    serr_cnt += int'(seq_err);
  endtask

  task automatic hold(input logic [23:0] l, input int n);
    light = l;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic add(input logic r, input logic [23:0] l, input int c, input logic [2:0] col,
                     input int v, input int s, input int e, input logic w);
    vec_t x;
    x.rst = r; x.light = l; x.cyc = c; x.colour = col;
    x.vld = v; x.serr = s; x.err = e; x.white = w;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 1'b1; light = 24'hFF0000; clr_err = 1'b0;
    vld_cnt = 0; serr_cnt = 0;
    @(negedge clk);

    // Reset then exact accept latency: pulse at the 3rd edge after release.
    step(); step();
    check("rst_colour", int'(colour), 0);
    check("rst_valid", int'(colour_valid), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_white", int'(white), 0);
    rst = 1'b0;
    step(); check("lat_e1_valid", int'(colour_valid), 0);
    step(); check("lat_e2_valid", int'(colour_valid), 0);
    check("lat_e2_colour", int'(colour), 0);
    step(); check("lat_e3_valid", int'(colour_valid), 1);
    check("lat_e3_colour", int'(colour), 4);
    step(); check("lat_e4_valid", int'(colour_valid), 0);
    check("lat_e4_colour", int'(colour), 4);

    //   rst  light       cyc col vld serr err white
    add(1'b1, 24'h000000, 2, 0, 0, 0, 0, 1'b0);
    add(1'b0, 24'h0000FF, 4, 1, 1, 0, 0, 1'b0);
    add(1'b0, 24'h00FF00, 4, 2, 1, 0, 0, 1'b0);
    add(1'b0, 24'h00FFFF, 4, 3, 1, 0, 0, 1'b0);
    add(1'b0, 24'hFF0000, 4, 4, 1, 0, 0, 1'b0);
    add(1'b0, 24'hFF00FF, 4, 5, 1, 0, 0, 1'b0);
    add(1'b0, 24'hFFFF00, 4, 6, 1, 0, 0, 1'b0);
    add(1'b0, 24'h0000FF, 4, 1, 1, 0, 0, 1'b0);
    add(1'b0, 24'h00FF00, 4, 2, 1, 0, 0, 1'b0);
    add(1'b0, 24'hFF0000, 1, 2, 0, 0, 0, 1'b0);
    add(1'b0, 24'h00FF00, 4, 2, 0, 0, 0, 1'b0);
    add(1'b0, 24'hFF00FF, 4, 5, 1, 1, 1, 1'b0);
    add(1'b1, 24'h000000, 2, 0, 0, 0, 0, 1'b0);
    add(1'b0, 24'h00FFFF, 4, 3, 1, 0, 0, 1'b0);
    add(1'b0, 24'hFFFFFF, 4, 7, 1, 0, 0, 1'b1);
    add(1'b0, 24'h00FF00, 4, 2, 1, 0, 0, 1'b0);
    add(1'b0, 24'hFF0000, 4, 4, 1, 1, 1, 1'b0);
    add(1'b0, 24'h000000, 4, 0, 1, 1, 2, 1'b0);
    add(1'b0, 24'h00FFFF, 4, 3, 1, 0, 2, 1'b0);
    add(1'b1, 24'h000000, 2, 0, 0, 0, 0, 1'b0);
`ifdef STRICT_DECODE_EN
    add(1'b0, 24'h804020, 5, 0, 0, 0, 1, 1'b0);
    add(1'b0, 24'h00FF00, 4, 2, 1, 0, 1, 1'b0);
`else
    add(1'b0, 24'h804020, 4, 4, 1, 0, 0, 1'b0);
    add(1'b0, 24'h7FFF80, 4, 3, 1, 1, 1, 1'b0);
`endif

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      vld_cnt = 0; serr_cnt = 0;
      hold(vecs[i].light, vecs[i].cyc);
      check($sformatf("v%0d_colour", i), int'(colour), int'(vecs[i].colour));
      check($sformatf("v%0d_valid_pulses", i), vld_cnt, vecs[i].vld);
      check($sformatf("v%0d_seq_err_pulses", i), serr_cnt, vecs[i].serr);
      check($sformatf("v%0d_err_count", i), int'(err_count), vecs[i].err);
      check($sformatf("v%0d_white", i), int'(white), int'(vecs[i].white));
    end

    // clr_err coinciding with a sequence error: clear wins.
    rst = 1'b1; hold(24'h000000, 2);
    rst = 1'b0;
    hold(24'h00FF00, 4);
    hold(24'hFF00FF, 4);
    check("pre_clr_err", int'(err_count), 1);
    light = 24'h00FF00;
    step(); step();
    clr_err = 1'b1;
    step();
    check("clr_seq_err", int'(seq_err), 1);
    check("clr_valid", int'(colour_valid), 1);
    check("clr_err_count", int'(err_count), 0);
    clr_err = 1'b0;
    step();
    check("clr_err_after", int'(err_count), 0);

    // Saturation: alternate 4 and 1 from TRACK, every accept is out of sequence.
    for (int n = 0; n < 130; n++) begin
      hold(24'hFF0000, 3);
      hold(24'h0000FF, 3);
    end
    check("sat_err_count", int'(err_count), 255);
    check("sat_colour", int'(colour), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
